// File: rtl/regb_fifo_pkg.sv
// Shared definitions for the register-based FIFO: cell select encoding and
// the ceiling-log2 helper used to size the fill counter.
package regb_fifo_pkg;

   typedef enum logic [1:0] {
      SEL_HOLD = 2'd0,
      SEL_UP   = 2'd1,
      SEL_IN   = 2'd2
   } cell_sel_e;

   function automatic int clog2(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      for (int k = 0; k < 32; k++) begin
         if (v > 0) begin
            r = r + 1;
            v = v >> 1;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/regb_fifo_cell.sv
// One storage cell of the shift FIFO: holds, takes the upstream cell, or loads
// the write word, as chosen by the controller.
module regb_fifo_cell
   import regb_fifo_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             res,
   input  logic             clear,
   input  logic [1:0]       sel,
   input  logic [WIDTH-1:0] up_data,
   input  logic             up_valid,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] data,
   output logic             valid
);

   always_ff @(posedge clk) begin
      if (res || clear) begin
         data  <= '0;
         valid <= 1'b0;
      end else begin
         case (sel)
            SEL_UP: begin
               data  <= up_data;
               valid <= up_valid;
            end
            SEL_IN: begin
               data  <= data_in;
               valid <= 1'b1;
            end
            default: begin
               data  <= data;
               valid <= valid;
            end
         endcase
      end
   end

endmodule

// File: rtl/regb_fifo_param.sv
// First-word-fall-through FIFO built from a chain of shift cells, with fill
// count, threshold flags, synchronous flush and sticky error flags.
module regb_fifo_param
   import regb_fifo_pkg::*;
#(
   parameter int WIDTH    = 4,
   parameter int DEPTH    = 8,
   parameter int AF_LEVEL = 7,
   parameter int AE_LEVEL = 1
) (
   input  logic                        clk,
   input  logic                        res,
   input  logic                        clear,
   input  logic                        shift_in,
   input  logic [WIDTH-1:0]            data_in,
   input  logic                        shift_out,
   output logic [WIDTH-1:0]            data_out,
   output logic                        empty,
   output logic                        full,
   output logic [clog2(DEPTH+1)-1:0]   count,
   output logic                        almost_full,
   output logic                        almost_empty,
   output logic                        overflow,
   output logic                        underflow
);

   localparam int CW = clog2(DEPTH + 1);

   // Index DEPTH is a constant empty cell feeding the top of the chain.
   logic [DEPTH:0][WIDTH-1:0] cell_data;
   logic [DEPTH:0]            cell_valid;
   logic [DEPTH-1:0][1:0]     cell_sel;

   logic          rd;
   logic          wr;
   logic [CW-1:0] wr_idx;
   logic [CW-1:0] count_next;

   assign cell_data[DEPTH]  = '0;
   assign cell_valid[DEPTH] = 1'b0;

   assign empty    = ~cell_valid[0];
   assign full     = cell_valid[DEPTH-1];
   assign data_out = cell_data[0];

   assign rd = shift_out & ~empty;
   assign wr = shift_in & (~full | shift_out);

   // On a concurrent read the tail has already moved down one place.
   assign wr_idx = rd ? (count - CW'(1)) : count;

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         cell_sel[i] = SEL_HOLD;
         if (rd) begin
            cell_sel[i] = SEL_UP;
         end
         if (wr && (wr_idx == CW'(i))) begin
            cell_sel[i] = SEL_IN;
         end
      end
   end

   always_comb begin
      count_next = count;
      case ({rd, wr})
         2'b10:   count_next = count - CW'(1);
         2'b01:   count_next = count + CW'(1);
         default: count_next = count;
      endcase
   end

   always_ff @(posedge clk) begin
      if (res || clear) begin
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         count <= count_next;
         if (shift_in && full && !shift_out) begin
            overflow <= 1'b1;
         end
         if (shift_out && empty) begin
            underflow <= 1'b1;
         end
      end
   end

   assign almost_full  = (count >= CW'(AF_LEVEL));
   assign almost_empty = (count <= CW'(AE_LEVEL));

   for (genvar g = 0; g < DEPTH; g++) begin : g_cell
      regb_fifo_cell #(
         .WIDTH (WIDTH)
      ) u_cell (
         .clk      (clk),
         .res      (res),
         .clear    (clear),
         .sel      (cell_sel[g]),
         .up_data  (cell_data[g+1]),
         .up_valid (cell_valid[g+1]),
         .data_in  (data_in),
         .data     (cell_data[g]),
         .valid    (cell_valid[g])
      );
   end

endmodule

// File: tb/tb_regb_fifo_param.sv
// Directed and randomized checks of regb_fifo_param against a queue model.
module tb_regb_fifo_param;

   localparam int WIDTH = 4;
   localparam int DEPTH = 8;
   localparam int AF    = 7;
   localparam int AE    = 1;

   logic             clk = 1'b0;
   logic             res = 1'b0;
   logic             clear = 1'b0;
   logic             shift_in = 1'b0;
   logic [WIDTH-1:0] data_in = '0;
   logic             shift_out = 1'b0;
   logic [WIDTH-1:0] data_out;
   logic             empty;
   logic             full;
   logic [3:0]       count;
   logic             almost_full;
   logic             almost_empty;
   logic             overflow;
   logic             underflow;

   int vectors = 0;
   int miscompares = 0;

   logic [WIDTH-1:0] q[$];
   logic             m_ovf = 1'b0;
   logic             m_unf = 1'b0;

   regb_fifo_param #(
      .WIDTH    (WIDTH),
      .DEPTH    (DEPTH),
      .AF_LEVEL (AF),
      .AE_LEVEL (AE)
   ) dut (
      .clk          (clk),
      .res          (res),
      .clear        (clear),
      .shift_in     (shift_in),
      .data_in      (data_in),
      .shift_out    (shift_out),
      .data_out     (data_out),
      .empty        (empty),
      .full         (full),
      .count        (count),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .overflow     (overflow),
      .underflow    (underflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_edge();
      int  n;
      logic m_full, m_empty;
      n = q.size();
      m_full  = (n == DEPTH);
      m_empty = (n == 0);
      if (res || clear) begin
         q.delete();
         m_ovf = 1'b0;
         m_unf = 1'b0;
      end else begin
         if (shift_in && m_full && !shift_out) m_ovf = 1'b1;
         if (shift_out && m_empty) m_unf = 1'b1;
         if (shift_out && !m_empty) void'(q.pop_front());
         if (shift_in && (!m_full || shift_out)) q.push_back(data_in);
      end
   endtask

   task automatic check_all(input string tag);
      int n;
      logic [WIDTH-1:0] head;
      n = q.size();
      head = (n > 0) ? q[0] : '0;
      chk({tag, ".data_out"}, 32'(data_out), 32'(head));
      chk({tag, ".count"}, 32'(count), 32'(n));
      chk({tag, ".empty"}, 32'(empty), 32'(n == 0));
      chk({tag, ".full"}, 32'(full), 32'(n == DEPTH));
      chk({tag, ".almost_full"}, 32'(almost_full), 32'(n >= AF));
      chk({tag, ".almost_empty"}, 32'(almost_empty), 32'(n <= AE));
      chk({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
      chk({tag, ".underflow"}, 32'(underflow), 32'(m_unf));
   endtask

   task automatic step(input string tag, input logic r, input logic c,
                       input logic si, input logic [WIDTH-1:0] d, input logic so);
      res = r;
      clear = c;
      shift_in = si;
      data_in = d;
      shift_out = so;
      @(posedge clk);
      #1;
      model_edge();
      check_all(tag);
   endtask

   initial begin
      // Reset held two edges with a pending write that must be ignored.
      step("reset0", 1, 0, 1, 4'hA, 0);
      step("reset1", 1, 0, 1, 4'hA, 0);
      chk("reset.count", 32'(count), 0);
      chk("reset.data_out", 32'(data_out), 0);

      // Fill with 1..8, then drain.
      for (int i = 1; i <= DEPTH; i++) step("fill", 0, 0, 1, WIDTH'(i), 0);
      chk("fill.full", 32'(full), 1);
      chk("fill.count", 32'(count), 8);
      for (int i = 1; i <= DEPTH; i++) begin
         chk("drain.order", 32'(data_out), 32'(i));
         step("drain", 0, 0, 0, 4'h0, 1);
      end
      chk("drain.empty", 32'(empty), 1);

      // Simultaneous read and write while full.
      for (int i = 1; i <= DEPTH; i++) step("fill2", 0, 0, 1, WIDTH'(i), 0);
      step("simul", 0, 0, 1, 4'h9, 1);
      chk("simul.data_out", 32'(data_out), 2);
      chk("simul.count", 32'(count), 8);
      chk("simul.overflow", 32'(overflow), 0);

      // Overflow: write while full without a read.
      step("ovf", 0, 0, 1, 4'hF, 0);
      chk("ovf.flag", 32'(overflow), 1);
      for (int i = 2; i <= 9; i++) begin
         chk("ovf.drain", 32'(data_out), 32'(i));
         step("ovf.drain", 0, 0, 0, 4'h0, 1);
      end

      // Underflow with concurrent write into an empty FIFO.
      step("unf", 0, 0, 1, 4'h3, 1);
      chk("unf.flag", 32'(underflow), 1);
      chk("unf.count", 32'(count), 1);
      chk("unf.data_out", 32'(data_out), 3);

      // Clear mid-operation drops a concurrent write and flags.
      for (int i = 0; i < 4; i++) step("pre_clr", 0, 0, 1, WIDTH'(i + 4), 0);
      chk("pre_clr.count", 32'(count), 5);
      step("clear", 0, 1, 1, 4'hC, 0);
      chk("clear.count", 32'(count), 0);
      chk("clear.underflow", 32'(underflow), 0);

      // Fall-through latency.
      step("fwft.wr", 0, 0, 1, 4'h6, 0);
      chk("fwft.data_out", 32'(data_out), 6);
      chk("fwft.empty", 32'(empty), 0);
      step("fwft.rd", 0, 0, 0, 4'h0, 1);
      chk("fwft.empty_after", 32'(empty), 1);

      // Randomized traffic with rare flush/reset.
      for (int i = 0; i < 400; i++) begin
         logic r, c, si, so;
         r  = ($urandom_range(0, 99) == 0);
         c  = ($urandom_range(0, 49) == 0);
         si = ($urandom_range(0, 99) < 55);
         so = ($urandom_range(0, 99) < 45);
         step("rand", r, c, si, WIDTH'($urandom), so);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
